// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : booth_pkg
// Brief    : Shared state encoding and Booth decision codes for the
//            radix-2 Booth multiplier controller.
// Revision : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int BOOTH_WIDTH = 6;

    // {Y0,Y-1} codes that require an adder operation; 00/11 skip.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_X  = 3'd1,
        LOAD_Y  = 3'd2,
        ADD_SUB = 3'd3,
        SHIFT   = 3'd4,
        OUT_HI  = 3'd5,
        OUT_LO  = 3'd6
    } boothState_t;

endpackage
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
// Module   : booth_controller
// Brief    : Sequencing FSM for the radix-2 Booth multiplier datapath with a
//            start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] Y0Yminus1,
    output logic       ldX,
    output logic       ldY,
    output logic       ldA,
    output logic       initA,
    output logic       initYminusOne,
    output logic       aBarS,
    output logic       shRA,
    output logic       shRY,
    output logic       ldYminusOne,
    output logic       selL,
    output logic       selR,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] c_LAST_ITER = CNT_W'(WIDTH - 1);

    boothState_t      r_state;
    boothState_t      w_nextState;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextCount   = r_count;
        ldX           = 1'b0;
        ldY           = 1'b0;
        ldA           = 1'b0;
        initA         = 1'b0;
        initYminusOne = 1'b0;
        aBarS         = 1'b0;
        shRA          = 1'b0;
        shRY          = 1'b0;
        ldYminusOne   = 1'b0;
        selL          = 1'b0;
        selR          = 1'b0;
        busy          = (r_state != IDLE);
        done          = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) w_nextState = LOAD_X;
            end
            LOAD_X: begin
                ldX           = 1'b1;
                initA         = 1'b1;
                initYminusOne = 1'b1;
                w_nextCount   = '0;
                w_nextState   = LOAD_Y;
            end
            LOAD_Y: begin
                ldY         = 1'b1;
                w_nextState = ADD_SUB;
            end
            ADD_SUB: begin
                // Mealy decode of the datapath status; 00/11 leave A untouched.
                if (Y0Yminus1 == BOOTH_ADD) begin
                    ldA = 1'b1;
                end else if (Y0Yminus1 == BOOTH_SUB) begin
                    ldA   = 1'b1;
                    aBarS = 1'b1;
                end
                w_nextState = SHIFT;
            end
            SHIFT: begin
                shRA        = 1'b1;
                shRY        = 1'b1;
                ldYminusOne = 1'b1;
                w_nextCount = r_count + 1'b1;
                w_nextState = (r_count == c_LAST_ITER) ? OUT_HI : ADD_SUB;
            end
            OUT_HI: begin
                selL        = 1'b1;
                w_nextState = OUT_LO;
            end
            OUT_LO: begin
                selR        = 1'b1;
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_controller
// Brief    : Self-checking bench: cycle-position reference model plus
//            directed handshake/reset scenarios for booth_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_controller;

    localparam int WIDTH   = 6;
    localparam int OP_LEN  = 2 + 2 * WIDTH + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] Y0Yminus1 = 2'b00;
    logic       ldX, ldY, ldA, initA, initYminusOne, aBarS;
    logic       shRA, shRY, ldYminusOne, selL, selR, busy, done;

    int nTests = 0;
    int nFail  = 0;

    booth_controller #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Y0Yminus1    (Y0Yminus1),
        .ldX          (ldX),
        .ldY          (ldY),
        .ldA          (ldA),
        .initA        (initA),
        .initYminusOne(initYminusOne),
        .aBarS        (aBarS),
        .shRA         (shRA),
        .shRY         (shRY),
        .ldYminusOne  (ldYminusOne),
        .selL         (selL),
        .selR         (selR),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        nTests++;
        if (actual !== expected) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: position within an operation (0 = idle, 1..OP_LEN).
    int opCycle = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst)                opCycle <= 0;
        else if (opCycle == 0)   opCycle <= start ? 1 : 0;
        else if (opCycle == OP_LEN) opCycle <= 0;
        else                     opCycle <= opCycle + 1;
    end

    // Output vector order: ldX ldY ldA initA initYm aBarS shRA shRY ldYm selL selR busy done
    function automatic logic [12:0] expOut(input int pos, input logic [1:0] yy);
        logic [12:0] e;
        e = '0;
        if (pos == 1)                 e = 13'b1001100000010;
        else if (pos == 2)            e = 13'b0100000000010;
        else if (pos >= 3 && pos <= 2 + 2 * WIDTH) begin
            if (pos % 2 == 1) begin
                e = 13'b0000000000010;
                if (yy == 2'b01) e[10] = 1'b1;
                if (yy == 2'b10) begin e[10] = 1'b1; e[7] = 1'b1; end
            end else begin
                e = 13'b0000001110010;
            end
        end
        else if (pos == OP_LEN - 1)   e = 13'b0000000001010;
        else if (pos == OP_LEN)       e = 13'b0000000000111;
        return e;
    endfunction

    logic [12:0] gotVec;
    assign gotVec = {ldX, ldY, ldA, initA, initYminusOne, aBarS,
                     shRA, shRY, ldYminusOne, selL, selR, busy, done};

    logic prevDone = 1'b0;

    always @(negedge clk) begin
        check("outputs_vs_model", int'(gotVec), int'(expOut(opCycle, Y0Yminus1)));
        if (selL && selR) check("selL_selR_exclusive", 1, 0);
        if (ldA && shRA)  check("ldA_shRA_exclusive", 1, 0);
        if (done && prevDone) check("done_one_cycle", 1, 0);
        prevDone <= done;
    end

    // Runs one operation with a fixed status code and records strobe timing.
    task automatic directedOp(input logic [1:0] yy, input bit poke,
                              output int ldxAt, output int ldyAt, output int selLAt,
                              output int doneAt, output int nLdA, output int nSub,
                              output int nShift);
        ldxAt = -1; ldyAt = -1; selLAt = -1; doneAt = -1;
        nLdA = 0; nSub = 0; nShift = 0;
        Y0Yminus1 = yy;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            start = (poke && (c == 3 || c == 10)) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (ldX  && ldxAt  < 0) ldxAt  = c;
            if (ldY  && ldyAt  < 0) ldyAt  = c;
            if (selL && selLAt < 0) selLAt = c;
            if (done && doneAt < 0) doneAt = c;
            if (ldA) nLdA++;
            if (ldA && aBarS) nSub++;
            if (shRA && shRY && ldYminusOne) nShift++;
            @(posedge clk); #1;
        end
    endtask

    int a, b, c, d, e, f, g;

    initial begin
        #2 rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        directedOp(2'b00, 1'b0, a, b, c, d, e, f, g);
        check("skip_ldX_cycle", a, 1);
        check("skip_ldY_cycle", b, 2);
        check("skip_selL_cycle", c, 15);
        check("skip_done_cycle", d, 16);
        check("skip_ldA_count", e, 0);
        check("skip_shift_count", g, 6);

        directedOp(2'b10, 1'b0, a, b, c, d, e, f, g);
        check("sub_ldA_count", e, 6);
        check("sub_aBarS_count", f, 6);

        directedOp(2'b01, 1'b0, a, b, c, d, e, f, g);
        check("add_ldA_count", e, 6);
        check("add_aBarS_count", f, 0);

        directedOp(2'b11, 1'b0, a, b, c, d, e, f, g);
        check("skip11_ldA_count", e, 0);

        directedOp(2'b00, 1'b1, a, b, c, d, e, f, g);
        check("poke_done_cycle", d, 16);

        // Held start: done, one IDLE cycle, then LOAD_X again.
        start = 1'b1;
        Y0Yminus1 = 2'b00;
        a = -1;
        b = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done && a < 0) a = k;
            if (ldX && a > 0 && b < 0) b = k;
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b_restart_gap", b - a, 2);
        repeat (20) @(posedge clk);
        #1;

        // Asynchronous reset in the third ADD_SUB cycle.
        start = 1'b1;
        Y0Yminus1 = 2'b01;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 7; k++) @(posedge clk);
        @(negedge clk);
        check("pre_reset_ldA", int'(ldA), 1);
        #1 rst = 1'b0;
        #1;
        check("midop_reset_outputs", int'(gotVec), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        directedOp(2'b00, 1'b0, a, b, c, d, e, f, g);
        check("post_reset_done_cycle", d, 16);

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            start     = ($urandom_range(0, 3) == 0);
            Y0Yminus1 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk); #1;
                rst = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
